// File: rtl/pipeline_hazard_ctrl.sv
// Hazard unit for a 5-stage pipeline: load-use stalls, branch flushes, E-stage forwarding and dmem wait handling.
// Forwarding is enabled by defining HAZARD_FWD_EN; otherwise every RAW hazard against E or M is resolved by stalling.
module pipeline_hazard_ctrl #(
   parameter int unsigned REGBITS     = 5,
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [REGBITS-1:0] rs1D,
   input  logic [REGBITS-1:0] rs2D,
   input  logic [REGBITS-1:0] rdD,
   input  logic               regwriteD,
   input  logic [1:0]         resultsrcD,
   input  logic               pcsrcE,
   input  logic               memreqM,
   input  logic               memreadyM,
   output logic               stallF,
   output logic               stallD,
   output logic               stallE,
   output logic               stallM,
   output logic               flushD,
   output logic               flushE,
   output logic [1:0]         forwardAE,
   output logic [1:0]         forwardBE,
   output logic [REGBITS-1:0] rs1E,
   output logic [REGBITS-1:0] rs2E,
   output logic [REGBITS-1:0] rdE,
   output logic [REGBITS-1:0] rdM,
   output logic [REGBITS-1:0] rdW,
   output logic               regwriteM,
   output logic               regwriteW,
   output logic               memwait,
   output logic               memerr
);

   localparam int unsigned CNTW = 8;

   typedef enum logic {
      ST_IDLE,
      ST_WAIT
   } wait_state_t;

   wait_state_t     state;
   logic [CNTW-1:0] cnt;
   logic [CNTW-1:0] cnt_inc;
   logic            regwrite_e;
   logic            isload_e;
   logic            mem_wait;
   logic            branch;
   logic            match_e;
   logic            hazard;

   // Reset forces every control output low, including the purely combinational wait
   assign mem_wait = rst & memreqM & ~memreadyM;
   assign branch   = rst & pcsrcE;
   assign memwait  = mem_wait;
   assign match_e  = (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));
   assign cnt_inc  = cnt + CNTW'(1);

`ifdef HAZARD_FWD_EN
   assign hazard = isload_e & regwrite_e & match_e;

   // M has priority over W; index 0 never forwards
   always_comb begin
      forwardAE = 2'b00;
      forwardBE = 2'b00;
      if (regwriteM && (rdM != '0) && (rdM == rs1E))
         forwardAE = 2'b10;
      else if (regwriteW && (rdW != '0) && (rdW == rs1E))
         forwardAE = 2'b01;
      if (regwriteM && (rdM != '0) && (rdM == rs2E))
         forwardBE = 2'b10;
      else if (regwriteW && (rdW != '0) && (rdW == rs2E))
         forwardBE = 2'b01;
   end
`else
   logic match_m;
   logic unused_isload;

   assign match_m       = (rdM != '0) && ((rdM == rs1D) || (rdM == rs2D));
   assign hazard        = (regwrite_e & match_e) | (regwriteM & match_m);
   assign forwardAE     = 2'b00;
   assign forwardBE     = 2'b00;
   assign unused_isload = isload_e;
`endif

   // A memory wait freezes everything and defers any branch flush until it clears
   always_comb begin
      stallF = 1'b0;
      stallD = 1'b0;
      stallE = 1'b0;
      stallM = 1'b0;
      flushD = 1'b0;
      flushE = 1'b0;
      if (mem_wait) begin
         stallF = 1'b1;
         stallD = 1'b1;
         stallE = 1'b1;
         stallM = 1'b1;
      end else if (branch) begin
         flushD = 1'b1;
         flushE = 1'b1;
      end else if (hazard) begin
         stallF = 1'b1;
         stallD = 1'b1;
         flushE = 1'b1;
      end
   end

   // E stage tracking: bubble on flush, hold on stall
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rs1E       <= '0;
         rs2E       <= '0;
         rdE        <= '0;
         regwrite_e <= 1'b0;
         isload_e   <= 1'b0;
      end else if (flushE) begin
         rs1E       <= '0;
         rs2E       <= '0;
         rdE        <= '0;
         regwrite_e <= 1'b0;
         isload_e   <= 1'b0;
      end else if (!stallE) begin
         rs1E       <= rs1D;
         rs2E       <= rs2D;
         rdE        <= rdD;
         regwrite_e <= regwriteD;
         isload_e   <= (resultsrcD == 2'b01);
      end
   end

   // M holds during a wait while W takes a bubble
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdM       <= '0;
         regwriteM <= 1'b0;
         rdW       <= '0;
         regwriteW <= 1'b0;
      end else if (mem_wait) begin
         rdW       <= '0;
         regwriteW <= 1'b0;
      end else begin
         rdM       <= rdE;
         regwriteM <= regwrite_e;
         rdW       <= rdM;
         regwriteW <= regwriteM;
      end
   end

   // Wait tracker: counts stalled cycles past the first and raises a sticky timeout error
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         memerr <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               cnt <= '0;
               if (mem_wait)
                  state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (!mem_wait) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else begin
                  if (cnt != '1)
                     cnt <= cnt_inc;
                  if (cnt_inc == CNTW'(MEM_TIMEOUT))
                     memerr <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios then random traffic against an instruction-level pipeline model.
module tb_pipeline_hazard_ctrl;

   localparam int unsigned RB = 5;
   localparam int unsigned MT = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [RB-1:0] rs1D, rs2D, rdD;
   logic          regwriteD;
   logic [1:0]    resultsrcD;
   logic          pcsrcE, memreqM, memreadyM;
   logic          stallF, stallD, stallE, stallM, flushD, flushE;
   logic [1:0]    forwardAE, forwardBE;
   logic [RB-1:0] rs1E, rs2E, rdE, rdM, rdW;
   logic          regwriteM, regwriteW, memwait, memerr;

   int checks = 0;
   int errors = 0;

   // One in-flight instruction as the hazard unit sees it
   typedef struct {
      int rs1;
      int rs2;
      int rd;
      bit rw;
      bit ld;
   } instr_t;

   instr_t stg_e, stg_m, stg_w;
   int     run;
   bit     err;

   pipeline_hazard_ctrl #(.REGBITS(RB), .MEM_TIMEOUT(MT)) dut (
      .clk(clk), .rst(rst),
      .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD), .regwriteD(regwriteD), .resultsrcD(resultsrcD),
      .pcsrcE(pcsrcE), .memreqM(memreqM), .memreadyM(memreadyM),
      .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
      .flushD(flushD), .flushE(flushE), .forwardAE(forwardAE), .forwardBE(forwardBE),
      .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .rdM(rdM), .rdW(rdW),
      .regwriteM(regwriteM), .regwriteW(regwriteW), .memwait(memwait), .memerr(memerr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic instr_t bubble();
      instr_t b;
      b = '{default: 0};
      return b;
   endfunction

   task automatic model_clear();
      stg_e = bubble();
      stg_m = bubble();
      stg_w = bubble();
      run   = 0;
      err   = 1'b0;
   endtask

   task automatic drive(input int r1, input int r2, input int rd, input bit rw, input int rsrc,
                        input bit pc, input bit mreq, input bit mrdy);
      rs1D       = RB'(r1);
      rs2D       = RB'(r2);
      rdD        = RB'(rd);
      regwriteD  = rw;
      resultsrcD = 2'(rsrc);
      pcsrcE     = pc;
      memreqM    = mreq;
      memreadyM  = mrdy;
   endtask

   function automatic bit reads(instr_t s);
      return s.rw && (s.rd != 0) && ((s.rd == int'(rs1D)) || (s.rd == int'(rs2D)));
   endfunction

   function automatic int fsel(int src);
`ifdef HAZARD_FWD_EN
      if (stg_m.rw && stg_m.rd != 0 && stg_m.rd == src) return 2;
      if (stg_w.rw && stg_w.rd != 0 && stg_w.rd == src) return 1;
`endif
      return 0;
   endfunction

   // Compare every output with the model, then advance the model across the clock edge
   task automatic step();
      bit mw, pc, hz, sf, fd, fe;
      instr_t d, ne, nm, nw;
      #2;
      mw = rst && memreqM && !memreadyM;
      pc = rst && pcsrcE;
`ifdef HAZARD_FWD_EN
      hz = rst && stg_e.ld && reads(stg_e);
`else
      hz = rst && (reads(stg_e) || reads(stg_m));
`endif
      sf = mw || (!pc && hz);
      fd = !mw && pc;
      fe = !mw && (pc || hz);
      chk("stallF", 8'(stallF), 8'(sf));
      chk("stallD", 8'(stallD), 8'(sf));
      chk("stallE", 8'(stallE), 8'(mw));
      chk("stallM", 8'(stallM), 8'(mw));
      chk("flushD", 8'(flushD), 8'(fd));
      chk("flushE", 8'(flushE), 8'(fe));
      chk("memwait", 8'(memwait), 8'(mw));
      chk("memerr", 8'(memerr), 8'(err));
      chk("forwardAE", 8'(forwardAE), 8'(fsel(stg_e.rs1)));
      chk("forwardBE", 8'(forwardBE), 8'(fsel(stg_e.rs2)));
      chk("rs1E", 8'(rs1E), 8'(stg_e.rs1));
      chk("rs2E", 8'(rs2E), 8'(stg_e.rs2));
      chk("rdE", 8'(rdE), 8'(stg_e.rd));
      chk("rdM", 8'(rdM), 8'(stg_m.rd));
      chk("rdW", 8'(rdW), 8'(stg_w.rd));
      chk("regwriteM", 8'(regwriteM), 8'(stg_m.rw));
      chk("regwriteW", 8'(regwriteW), 8'(stg_w.rw));
      d = '{int'(rs1D), int'(rs2D), int'(rdD), regwriteD, resultsrcD == 2'b01};
      @(posedge clk);
      if (rst) begin
         nw = mw ? bubble() : stg_m;
         nm = mw ? stg_m : stg_e;
         ne = fe ? bubble() : (mw ? stg_e : d);
         stg_w = nw;
         stg_m = nm;
         stg_e = ne;
         run = mw ? run + 1 : 0;
         if (run >= int'(MT) + 1) err = 1'b1;
      end
      #1;
   endtask

   task automatic reset_pulse();
      rst = 1'b0;
      model_clear();
      step();
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      model_clear();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step();

      // add x5 ; add x6,x5,x1 ; consumer of x5
      drive(1, 2, 5, 1, 0, 0, 0, 0);
      step();
      drive(5, 1, 6, 1, 0, 0, 0, 0);
`ifdef HAZARD_FWD_EN
      #1; chk("alu_no_stall", 8'(stallF), 8'd0);
      step();
      drive(5, 0, 9, 1, 0, 0, 0, 0);
      #1; chk("fwd_from_m", 8'(forwardAE), 8'd2);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1; chk("fwd_from_w", 8'(forwardAE), 8'd1);
      step();
`else
      #1; chk("raw_stall_1", 8'(stallF), 8'd1);
      step();
      #1; chk("raw_stall_2", 8'(stallF), 8'd1);
      chk("fwd_disabled", 8'(forwardAE), 8'd0);
      step();
      #1; chk("raw_stall_done", 8'(stallF), 8'd0);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step();
`endif

      // lw x7 ; add x8,x7,x7
      drive(0, 0, 7, 1, 1, 0, 0, 0);
      step();
      drive(7, 7, 8, 1, 0, 0, 0, 0);
      #1; chk("load_use_stall", 8'(stallF), 8'd1);
      chk("load_use_flushE", 8'(flushE), 8'd1);
      step();
`ifdef HAZARD_FWD_EN
      #1; chk("load_use_once", 8'(stallF), 8'd0);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1; chk("load_fwdA", 8'(forwardAE), 8'd1);
      chk("load_fwdB", 8'(forwardBE), 8'd1);
      step();
`else
      #1; chk("load_stall_m", 8'(stallF), 8'd1);
      step();
      #1; chk("load_stall_done", 8'(stallF), 8'd0);
      step();
`endif

      // Taken branch overrides a load-use stall
      drive(0, 0, 7, 1, 1, 0, 0, 0);
      step();
      drive(7, 0, 8, 1, 0, 1, 0, 0);
      #1; chk("br_flushD", 8'(flushD), 8'd1);
      chk("br_flushE", 8'(flushE), 8'd1);
      chk("br_no_stall", 8'(stallF), 8'd0);
      step();

      // Three-cycle memory wait with a timeout of 2
      drive(1, 1, 3, 1, 0, 0, 0, 0);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      drive(0, 0, 0, 0, 0, 1, 1, 0);
      for (int i = 0; i < 3; i++) begin
         #1; chk("wait_stallM", 8'(stallM), 8'd1);
         chk("wait_rdM_held", 8'(rdM), 8'd3);
         chk("wait_no_flush", 8'(flushD), 8'd0);
         if (i > 0) chk("wait_bubble_W", 8'(regwriteW), 8'd0);
         step();
      end
      drive(0, 0, 0, 0, 0, 0, 1, 1);
      #1; chk("memerr_set", 8'(memerr), 8'd1);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1; chk("memerr_sticky", 8'(memerr), 8'd1);
      step();

      // Reset in the middle of a wait
      reset_pulse();
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      step();
      step();
      rst = 1'b0;
      model_clear();
      #1; chk("rst_stallF", 8'(stallF), 8'd0);
      chk("rst_memwait", 8'(memwait), 8'd0);
      chk("rst_memerr", 8'(memerr), 8'd0);
      step();
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step();

      // Random traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         if (i % 100 == 50) reset_pulse();
         drive(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
               $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, bit'($urandom_range(0, 1)));
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter REGBITS, default 5, meaning register-index width.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 16, meaning memwait cycles before memerr, range 2..255.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports rs1D, rs2D, rdD  input  REGBITS  decode-stage source and destination indices.
REQ-006 SHALL have ports regwriteD  input  1 and resultsrcD  input  2 (01 = load), decode-stage controls.
REQ-007 SHALL have port pcsrcE  input  1  taken branch/jump resolved in E.
REQ-008 SHALL have ports memreqM  input  1 (load/store in M) and memreadyM  input  1 (dmem completes this cycle).
REQ-009 SHALL have outputs stallF, stallD, stallE, stallM, flushD, flushE, each 1 bit, pipeline-register controls.
REQ-010 SHALL have outputs forwardAE, forwardBE, each 2 bits: 00 regfile, 01 W result, 10 M ALU result.
REQ-011 SHALL have outputs rs1E, rs2E, rdE, rdM, rdW (REGBITS), regwriteM, regwriteW (1), tracked copies for the datapath.
REQ-012 SHALL have outputs memwait (1) and memerr (1, sticky).

Function
REQ-013 SHALL hold internal E/M/W tracking registers: E {rs1, rs2, rd, regwrite, isload}, M {rd, regwrite}, W {rd, regwrite}.
REQ-014 memwait SHALL equal memreqM & !memreadyM, combinationally.
REQ-015 On memwait: stallF=stallD=stallE=stallM=1, flushD=flushE=0; E and M regs hold; W loads a bubble (regwriteW=0, rdW=0).
REQ-016 Without memwait, M->W SHALL copy each rising edge; E->M SHALL copy each rising edge.
REQ-017 D->E SHALL capture D inputs each edge unless flushE (loads all-zero bubble) or stallE (holds).
REQ-018 loadstall SHALL be isloadE & regwriteE & rdE!=0 & (rdE==rs1D | rdE==rs2D).
REQ-019 On loadstall without pcsrcE: stallF=stallD=1, flushE=1, flushD=0; resolves after exactly one bubble.
REQ-020 On pcsrcE without memwait: flushD=flushE=1, stallF=stallD=0, overriding loadstall.
REQ-021 With memwait and pcsrcE, flushes SHALL be deferred; pcsrcE stays held in frozen E and acts on the first non-wait cycle.
REQ-022 Index 0 SHALL never create a hazard or a forward.
REQ-023 forwardAE SHALL be 10 if regwriteM & rdM!=0 & rdM==rs1E; else 01 if regwriteW & rdW!=0 & rdW==rs1E; else 00; M priority over W. forwardBE same using rs2E.
REQ-024 Register-file write-through SHALL be assumed done by the regfile; W vs D is not a hazard.
REQ-025 Wait FSM: IDLE -> WAIT on memwait; WAIT -> IDLE when memreadyM or !memreqM; 8-bit counter increments in WAIT, clears in IDLE.
REQ-026 memerr SHALL set on the edge where the counter reaches MEM_TIMEOUT, then stay 1 until reset; stalls continue regardless.

Reset
REQ-027 rst low SHALL asynchronously clear all tracking registers, FSM to IDLE, counter 0, memerr 0.
REQ-028 During and right after reset, all stall, flush and forward outputs SHALL be 0 (bubbles only); mid-wait reset aborts the wait.

Configuration
REQ-029 Macro HAZARD_FWD_EN SHALL select forwarding; defined: REQ-018..REQ-023 as written.
REQ-030 Without HAZARD_FWD_EN: forwardAE=forwardBE=00 always; any regwrite rd!=0 in E or M matching rs1D/rs2D SHALL stall F/D and flush E, regardless of isload.

Verification
REQ-031 add x5 then add x6,x5,x1 back-to-back -> cycle 2 forwardAE=10; one later consumer of x5 -> forwardAE=01.
REQ-032 lw x7 then add x8,x7,x7 -> one cycle stallF=stallD=flushE=1, then forwardAE=forwardBE=01, no second stall.
REQ-033 lw x7 in E with consumer in D plus pcsrcE=1 -> flushD=flushE=1, stallF=0.
REQ-034 memreqM=1, memreadyM=0 for 3 cycles -> all stalls 1 for 3 cycles, regwriteW=0, rdM held; MEM_TIMEOUT=2 -> memerr=1 stays after memreadyM.
REQ-035 rst low during WAIT -> outputs 0 immediately; HAZARD_FWD_EN undefined: add x5 then add x6,x5,x1 -> 2 stall cycles, forward 00.
